// File: rtl/code_sec_pkg.sv
`default_nettype none
// ============================================================================
// Module : code_sec_pkg
// Brief  : Shared code-security types: write-guard FSM states, policy
//          decision, code-window check and control readback bit positions.
// Rev    : 1.0  initial release
// ============================================================================
package code_sec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DENY = 2'd2
  } state_e;

  typedef enum logic {
    DEC_ALLOW = 1'b0,
    DEC_DENY  = 1'b1
  } decision_e;

  // Readback status bit positions, shared with the control block
  localparam int STAT_WP_BIT     = 0;
  localparam int STAT_LOCK_BIT   = 1;
  localparam int STAT_UPDATE_BIT = 2;
  localparam int STAT_FAULT_BIT  = 3;

  // Base must be aligned to size, and size must be a power of two
  function automatic logic in_code_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] size);
    return (addr & ~(size - 32'd1)) == base;
  endfunction

endpackage
`default_nettype wire

// File: rtl/code_wp_latch.sv
`default_nettype none
// ============================================================================
// Module : code_wp_latch
// Brief  : Sticky write-protect bit; set by pulse, cleared only by reset.
// Rev    : 1.0  initial release
// ============================================================================
module code_wp_latch (
  input  logic clk,
  input  logic rst,
  input  logic set_pulse_i,
  output logic wp_q_o
);

  logic r_wp;

  always_ff @(posedge clk) begin
    if (rst)              r_wp <= 1'b0;
    else if (set_pulse_i) r_wp <= 1'b1;
  end

  assign wp_q_o = r_wp;

endmodule
`default_nettype wire

// File: rtl/code_wr_guard.sv
`default_nettype none
// ============================================================================
// Module : code_wr_guard
// Brief  : Code-memory write guard: forwards allowed writes, completes denied
//          in-window writes locally with an error and logs them.
// Macro  : CODE_WR_GUARD_FAULT_LOG_EN implements the fault log outputs.
// Rev    : 1.0  initial release
// ============================================================================
module code_wr_guard
  import code_sec_pkg::*;
#(
  parameter logic [31:0] CODE_BASE = 32'h0000_0000,
  parameter logic [31:0] CODE_SIZE = 32'h0001_0000,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lock_i,
  input  logic             update_en_i,
  input  logic             wp_set_pulse_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  input  logic [3:0]       req_be_i,
  output logic             mem_valid_o,
  input  logic             mem_ready_i,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic [3:0]       mem_be_o,
  output logic             rsp_valid_o,
  output logic             rsp_err_o,
  output logic             wp_q_o,
  input  logic             fault_clr_i,
  output logic             fault_irq_o,
  output logic [31:0]      fault_addr_o,
  output logic [CNT_W-1:0] fault_cnt_o
);

  state_e      r_state;
  logic        r_ready;
  logic        r_mem_valid;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        w_wp_q;
  logic        w_in_win;
  logic        w_accept;
  logic        w_deny_entry;
  decision_e   w_dec;

  code_wp_latch u_wp_latch (
    .clk         (clk),
    .rst         (rst),
    .set_pulse_i (wp_set_pulse_i),
    .wp_q_o      (w_wp_q)
  );

  // Registered latch output means a same-cycle set pulse cannot affect this accept
  assign w_in_win     = in_code_window(req_addr_i, CODE_BASE, CODE_SIZE);
  assign w_dec        = (w_in_win && !(!w_wp_q && !lock_i && update_en_i)) ? DEC_DENY : DEC_ALLOW;
  assign w_accept     = (r_state == ST_IDLE) && req_valid_i;
  assign w_deny_entry = w_accept && (w_dec == DEC_DENY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b1;
      r_mem_valid <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_be    <= req_be_i;
            r_ready <= 1'b0;
            if (w_dec == DEC_ALLOW) begin
              r_state     <= ST_FWD;
              r_mem_valid <= 1'b1;
            end else begin
              r_state     <= ST_DENY;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        ST_FWD: begin
          if (mem_ready_i) begin
            r_state     <= ST_IDLE;
            r_mem_valid <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_ready     <= 1'b1;
          end
        end
        ST_DENY: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_ready     <= 1'b1;
          r_mem_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = r_ready;
  assign mem_valid_o = r_mem_valid;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_be_o    = r_be;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign wp_q_o      = w_wp_q;

`ifdef CODE_WR_GUARD_FAULT_LOG_EN
  logic             r_fault_vld;
  logic [31:0]      r_fault_addr;
  logic [CNT_W-1:0] r_fault_cnt;

  // A new denial outranks a simultaneous clear: it restarts the log
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault_vld  <= 1'b0;
      r_fault_addr <= '0;
      r_fault_cnt  <= '0;
    end else if (w_deny_entry) begin
      r_fault_vld <= 1'b1;
      if (!r_fault_vld || fault_clr_i) r_fault_addr <= req_addr_i;
      if (fault_clr_i)           r_fault_cnt <= CNT_W'(1);
      else if (!(&r_fault_cnt))  r_fault_cnt <= r_fault_cnt + CNT_W'(1);
    end else if (fault_clr_i) begin
      r_fault_vld <= 1'b0;
      r_fault_cnt <= '0;
    end
  end

  assign fault_irq_o  = r_fault_vld;
  assign fault_addr_o = r_fault_addr;
  assign fault_cnt_o  = r_fault_cnt;
`else
  logic w_unused_fault;
  assign w_unused_fault = fault_clr_i ^ w_deny_entry;
  assign fault_irq_o    = 1'b0;
  assign fault_addr_o   = '0;
  assign fault_cnt_o    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_code_wr_guard.sv
`default_nettype none
// ============================================================================
// Module : tb_code_wr_guard
// Brief  : Directed table-driven bench for code_wr_guard (CNT_W 8 and 2).
// Rev    : 1.0  initial release
// ============================================================================
module tb_code_wr_guard;

`ifdef CODE_WR_GUARD_FAULT_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        lock_i, update_en_i, wp_set_pulse_i;
  logic        req_valid_i, req_ready_o;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_be_i;
  logic        mem_valid_o, mem_ready_i;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        rsp_valid_o, rsp_err_o, wp_q_o;
  logic        fault_clr_i, fault_irq_o;
  logic [31:0] fault_addr_o;
  logic [7:0]  fault_cnt_o;

  logic        req_ready2, mem_valid2, rsp_valid2, rsp_err2, wp_q2, fault_irq2;
  logic [31:0] mem_addr2, mem_wdata2, fault_addr2;
  logic [3:0]  mem_be2;
  logic [1:0]  fault_cnt2;

  always #5 clk = ~clk;

  code_wr_guard #(.CODE_BASE(32'h0000_0000), .CODE_SIZE(32'h0001_0000), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .lock_i(lock_i), .update_en_i(update_en_i),
    .wp_set_pulse_i(wp_set_pulse_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .rsp_valid_o(rsp_valid_o),
    .rsp_err_o(rsp_err_o), .wp_q_o(wp_q_o), .fault_clr_i(fault_clr_i),
    .fault_irq_o(fault_irq_o), .fault_addr_o(fault_addr_o), .fault_cnt_o(fault_cnt_o)
  );

  code_wr_guard #(.CODE_BASE(32'h0000_0000), .CODE_SIZE(32'h0001_0000), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .lock_i(lock_i), .update_en_i(update_en_i),
    .wp_set_pulse_i(wp_set_pulse_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready2),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .mem_valid_o(mem_valid2), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr2),
    .mem_wdata_o(mem_wdata2), .mem_be_o(mem_be2), .rsp_valid_o(rsp_valid2),
    .rsp_err_o(rsp_err2), .wp_q_o(wp_q2), .fault_clr_i(fault_clr_i),
    .fault_irq_o(fault_irq2), .fault_addr_o(fault_addr2), .fault_cnt_o(fault_cnt2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] ef(input logic [31:0] v);
    return LOG_EN ? v : 32'd0;
  endfunction

  // One write through the guard; inputs change 1 time unit after each edge
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input bit deny, input int stall, input bit clr, input bit wpp);
    chk("idle_ready", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_addr_i = a; req_wdata_i = d; req_be_i = be;
    fault_clr_i = clr; wp_set_pulse_i = wpp; mem_ready_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0; fault_clr_i = 1'b0; wp_set_pulse_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0; req_be_i = '0;
    if (deny) begin
      chk("deny_mem_valid", {31'd0, mem_valid_o}, 32'd0);
      chk("deny_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("deny_rsp_err",   {31'd0, rsp_err_o},   32'd1);
      @(posedge clk); #1;
      chk("deny_rsp_once",  {31'd0, rsp_valid_o}, 32'd0);
    end else begin
      for (int i = 0; i <= stall; i++) begin
        chk("fwd_mem_valid", {31'd0, mem_valid_o}, 32'd1);
        chk("fwd_rsp_quiet", {31'd0, rsp_valid_o}, 32'd0);
        chk("fwd_addr",  mem_addr_o, a);
        chk("fwd_wdata", mem_wdata_o, d);
        chk("fwd_be",    {28'd0, mem_be_o}, {28'd0, be});
        mem_ready_i = (i == stall);
        @(posedge clk); #1;
      end
      mem_ready_i = 1'b0;
      chk("fwd_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("fwd_rsp_err",   {31'd0, rsp_err_o},   32'd0);
      chk("fwd_mem_drop",  {31'd0, mem_valid_o}, 32'd0);
    end
  endtask

  typedef struct {
    logic        lock;
    logic        upd;
    logic        wpp;
    logic [31:0] addr;
    logic        deny;
    int          stall;
    logic        exp_wp;
    logic [31:0] exp_faddr;
    logic [31:0] exp_cnt;
    logic [31:0] exp_cnt2;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 0, 1'b0, 32'h0,   32'd0, 32'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0200, 1'b1, 0, 1'b0, 32'h200, 32'd1, 32'd1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 3, 1'b0, 32'h200, 32'd1, 32'd1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 0, 1'b0, 32'h200, 32'd2, 32'd2};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0002_0010, 1'b0, 1, 1'b0, 32'h200, 32'd2, 32'd2};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 0, 1'b1, 32'h200, 32'd3, 32'd3};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 0, 1'b1, 32'h200, 32'd3, 32'd3};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h0000_FFFC, 1'b1, 0, 1'b1, 32'h200, 32'd4, 32'd3};

    rst = 1'b1; lock_i = 1'b0; update_en_i = 1'b0; wp_set_pulse_i = 1'b0;
    req_valid_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; req_be_i = '0;
    mem_ready_i = 1'b0; fault_clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",     {31'd0, req_ready_o}, 32'd1);
    chk("rst_mem_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("rst_mem_addr",  mem_addr_o, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_wp",        {31'd0, wp_q_o}, 32'd0);
    chk("rst_irq",       {31'd0, fault_irq_o}, 32'd0);
    chk("rst_cnt",       {24'd0, fault_cnt_o}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      lock_i = tbl[i].lock; update_en_i = tbl[i].upd;
      if (tbl[i].wpp) begin
        wp_set_pulse_i = 1'b1;
        @(posedge clk); #1;
        wp_set_pulse_i = 1'b0;
      end
      xfer(tbl[i].addr, ~tbl[i].addr, 4'(i + 1), tbl[i].deny, tbl[i].stall, 1'b0, 1'b0);
      chk("tbl_wp",     {31'd0, wp_q_o}, {31'd0, tbl[i].exp_wp});
      chk("tbl_irq",    {31'd0, fault_irq_o}, ef({31'd0, tbl[i].exp_cnt != 0}));
      chk("tbl_faddr",  fault_addr_o, ef(tbl[i].exp_faddr));
      chk("tbl_cnt",    {24'd0, fault_cnt_o}, ef(tbl[i].exp_cnt));
      chk("tbl_cnt_w2", {30'd0, fault_cnt2}, ef(tbl[i].exp_cnt2));
    end

    // Clear, then first-fault retention and clear-vs-new-fault priority
    fault_clr_i = 1'b1;
    @(posedge clk); #1;
    fault_clr_i = 1'b0;
    chk("clr_irq", {31'd0, fault_irq_o}, 32'd0);
    chk("clr_cnt", {24'd0, fault_cnt_o}, 32'd0);
    lock_i = 1'b1;
    for (int i = 1; i <= 3; i++) xfer(32'(i * 16), 32'h0, 4'hF, 1'b1, 0, 1'b0, 1'b0);
    chk("first_faddr", fault_addr_o, ef(32'h10));
    chk("three_cnt",   {24'd0, fault_cnt_o}, ef(32'd3));
    xfer(32'h40, 32'h0, 4'hF, 1'b1, 0, 1'b1, 1'b0);
    chk("clrwin_faddr", fault_addr_o, ef(32'h40));
    chk("clrwin_cnt",   {24'd0, fault_cnt_o}, ef(32'd1));
    chk("clrwin_irq",   {31'd0, fault_irq_o}, ef(32'd1));
    for (int i = 0; i < 5; i++) xfer(32'h50 + 32'(i * 4), 32'h0, 4'hF, 1'b1, 0, 1'b0, 1'b0);
    chk("five_cnt",     {24'd0, fault_cnt_o}, ef(32'd6));
    chk("sat_cnt_w2",   {30'd0, fault_cnt2}, ef(32'd3));
    chk("wp_sticky",    {31'd0, wp_q_o}, 32'd1);

    // Decision frozen at accept; same-cycle WP pulse does not apply to it
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst2_wp", {31'd0, wp_q_o}, 32'd0);
    lock_i = 1'b0; update_en_i = 1'b1;
    req_valid_i = 1'b1; req_addr_i = 32'h300; req_wdata_i = 32'hA5A5_0300; req_be_i = 4'h3;
    wp_set_pulse_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0; wp_set_pulse_i = 1'b0; lock_i = 1'b1; update_en_i = 1'b0;
    chk("frz_mem_valid", {31'd0, mem_valid_o}, 32'd1);
    chk("frz_rsp_quiet", {31'd0, rsp_valid_o}, 32'd0);
    chk("frz_wp",        {31'd0, wp_q_o}, 32'd1);
    chk("frz_addr",      mem_addr_o, 32'h300);
    @(posedge clk); #1;
    chk("frz_hold", {31'd0, mem_valid_o}, 32'd1);
    mem_ready_i = 1'b1;
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    chk("frz_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("frz_rsp_err",   {31'd0, rsp_err_o}, 32'd0);

    // Reset in the middle of a forward drops it silently
    xfer(32'h500, 32'h0, 4'hF, 1'b1, 0, 1'b0, 1'b0);
    chk("pre_rst_cnt", {24'd0, fault_cnt_o}, ef(32'd1));
    req_valid_i = 1'b1; req_addr_i = 32'h0003_0000; req_wdata_i = 32'h1234_5678; req_be_i = 4'hF;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("mid_mem_valid", {31'd0, mem_valid_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_mem_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("mrst_ready",     {31'd0, req_ready_o}, 32'd1);
    chk("mrst_mem_addr",  mem_addr_o, 32'd0);
    chk("mrst_rsp",       {31'd0, rsp_valid_o}, 32'd0);
    chk("mrst_wp",        {31'd0, wp_q_o}, 32'd0);
    chk("mrst_irq",       {31'd0, fault_irq_o}, 32'd0);
    chk("mrst_faddr",     fault_addr_o, 32'd0);
    chk("mrst_cnt",       {24'd0, fault_cnt_o}, 32'd0);
    @(posedge clk); #1;
    chk("mrst_no_rsp",    {31'd0, rsp_valid_o}, 32'd0);
    chk("mrst_no_mem",    {31'd0, mem_valid_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
